// File: rtl/instruction_fetch_phase_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package instruction_fetch_phase_pkg;

    // Instruction inserted into IF/ID whenever it is squashed (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    // Default PC loaded on reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Sequential PC step.
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Next-PC source select, shared with decode/hazard logic.
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Pipeline condition of the fetch stage, decoded from inputs every cycle.
    typedef enum logic [1:0] {
        STG_RUN    = 2'd0,
        STG_HOLD   = 2'd1,
        STG_SQUASH = 2'd2
    } if_stage_e;

    // Word-align a redirect target; low two bits are never honoured.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_phase_if.sv
// Bundle of fetch-stage control, redirect, imem and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: Stall holds the stage; no valid/ready handshake on this bus.
interface instruction_fetch_phase_if;

    logic        Stall;
    logic        Flush;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        JumpRegister;
    logic [31:0] JumpRegTarget;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [31:0] fetch_count;

    // Fetch stage side.
    modport master (
        input  Stall, Flush,
        input  Branch, BranchTarget, Jump, JumpTarget, JumpRegister, JumpRegTarget,
        input  imem_data,
        output imem_addr, instr_out, pc_out, valid_out, fetch_count
    );

    // Decode / hazard / memory side.
    modport slave (
        output Stall, Flush,
        output Branch, BranchTarget, Jump, JumpTarget, JumpRegister, JumpRegTarget,
        output imem_data,
        input  imem_addr, instr_out, pc_out, valid_out, fetch_count
    );

endinterface

// File: rtl/instruction_fetch_phase_if_id_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Latency: 1 cycle from load to outputs.
// Backpressure: holds contents when neither load nor squash is asserted.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    // Squash wins over load; with neither asserted the register holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else if (squash_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_phase.sv
// Fetch stage: PC register, next-PC select, IF/ID register and fetch counter.
// Latency: instruction at PC=A appears on instr_out one edge later, pc_out=A+4.
// Backpressure: Stall freezes PC and IF/ID; redirects are ignored while stalled.
module instruction_fetch_phase #(
    parameter logic [31:0] RESET_PC  = instruction_fetch_phase_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = instruction_fetch_phase_pkg::NOP_INSTR
) (
    input  logic                      Clk,
    input  logic                      Reset,
    instruction_fetch_phase_if.master bus
);

    import instruction_fetch_phase_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    npc_sel_e    npc_sel;
    if_stage_e   stage;
    logic        ifid_load;
    logic        ifid_squash;

    assign pc_plus4 = pc_q + PC_INCR;
    assign redirect = bus.JumpRegister | bus.Jump | bus.Branch;

    // Next-PC source priority: JumpRegister > Jump > Branch > sequential.
    always_comb begin
        npc_sel    = NPC_SEQ;
        target_raw = pc_plus4;
        if (bus.JumpRegister) begin
            npc_sel    = NPC_JR;
            target_raw = bus.JumpRegTarget;
        end else if (bus.Jump) begin
            npc_sel    = NPC_J;
            target_raw = bus.JumpTarget;
        end else if (bus.Branch) begin
            npc_sel    = NPC_BR;
            target_raw = bus.BranchTarget;
        end
        target = (npc_sel == NPC_SEQ) ? pc_plus4 : align_target(target_raw);
    end

    // Decode the stage condition and derive PC, IF/ID and counter next state.
    always_comb begin
        stage       = STG_RUN;
        pc_d        = pc_plus4;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;
        count_d     = count_q;
        if (bus.Stall) begin
            // Decode re-presents any redirect once the stall clears.
            stage       = STG_HOLD;
            pc_d        = pc_q;
            ifid_squash = bus.Flush;
        end else if (redirect) begin
            // No delay slot: the word fetched alongside the redirect is dropped.
            stage       = STG_SQUASH;
            pc_d        = target;
            ifid_squash = 1'b1;
        end else if (bus.Flush) begin
            stage       = STG_SQUASH;
            ifid_squash = 1'b1;
        end else begin
            ifid_load = 1'b1;
            count_d   = count_q + 32'd1;
        end
    end

    // PC and fetch counter state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .load_i   (ifid_load),
        .squash_i (ifid_squash),
        .instr_i  (bus.imem_data),
        .pc_i     (pc_plus4),
        .instr_o  (bus.instr_out),
        .pc_o     (bus.pc_out),
        .valid_o  (bus.valid_out)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.fetch_count = count_q;

    // Stage code kept observable for hazard-side debug; not otherwise consumed.
    if_stage_e stage_dbg;
    assign stage_dbg = stage;

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Directed bench for the fetch stage with a rule-level reference model.
// Model advances on every rising edge; outputs compared #1 later.
// Stimulus is driven on falling edges.
module tb_instruction_fetch_phase;

    logic Clk;
    logic Reset;
    int   n_chk;
    int   n_pass;

    instruction_fetch_phase_if bus ();

    instruction_fetch_phase dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory contents: two fixed words, the rest address-derived.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        if (a == 32'h0000_0004) return 32'h2009_0003;
        return a ^ 32'h8C00_0000;
    endfunction

    assign bus.imem_data = imem_f(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pcout, m_count;
    logic        m_valid;
    bit          chk_en;

    // Apply the stage rules once per edge, then compare all outputs.
    always @(posedge Clk) begin
        logic [31:0] tgt;
        if (Reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0; m_count = 32'h0;
            chk_en = 1'b1;
        end else if (bus.Stall) begin
            if (bus.Flush) begin
                m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
            end
        end else if (bus.JumpRegister || bus.Jump || bus.Branch) begin
            tgt = bus.JumpRegister ? bus.JumpRegTarget :
                  bus.Jump         ? bus.JumpTarget    : bus.BranchTarget;
            m_pc = tgt & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
        end else begin
            if (bus.Flush) begin
                m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = imem_f(m_pc);
                m_pcout = m_pc + 32'd4;
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end
            m_pc = m_pc + 32'd4;
        end
        #1;
        if (chk_en) begin
            chk("model_imem_addr",   bus.imem_addr,          m_pc);
            chk("model_instr_out",   bus.instr_out,          m_instr);
            chk("model_pc_out",      bus.pc_out,             m_pcout);
            chk("model_valid_out",   {31'd0, bus.valid_out}, {31'd0, m_valid});
            chk("model_fetch_count", bus.fetch_count,        m_count);
        end
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clear_redirect();
        bus.Branch = 1'b0; bus.Jump = 1'b0; bus.JumpRegister = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; chk_en = 1'b0;
        Reset = 1'b1;
        bus.Stall = 1'b0; bus.Flush = 1'b0;
        bus.Branch = 1'b0; bus.BranchTarget = 32'h0;
        bus.Jump = 1'b0; bus.JumpTarget = 32'h0;
        bus.JumpRegister = 1'b0; bus.JumpRegTarget = 32'h0;
        step(); step();
        chk("rst_pc",    bus.imem_addr,          32'h0);
        chk("rst_instr", bus.instr_out,          32'h0);
        chk("rst_pcout", bus.pc_out,             32'h0);
        chk("rst_valid", {31'd0, bus.valid_out}, 32'h0);
        chk("rst_count", bus.fetch_count,        32'h0);
        Reset = 1'b0;

        // Free run from reset.
        step();
        chk("run1_instr", bus.instr_out,          32'h2008_0005);
        chk("run1_pcout", bus.pc_out,             32'h4);
        chk("run1_valid", {31'd0, bus.valid_out}, 32'h1);
        step();
        chk("run2_instr", bus.instr_out,   32'h2009_0003);
        chk("run2_pcout", bus.pc_out,      32'h8);
        chk("run2_count", bus.fetch_count, 32'h2);
        step(); step();
        chk("pc_at_10", bus.imem_addr, 32'h10);

        // Taken branch squashes IF/ID, no delay slot.
        bus.Branch = 1'b1; bus.BranchTarget = 32'h40;
        step();
        clear_redirect();
        chk("br_pc",    bus.imem_addr,          32'h40);
        chk("br_valid", {31'd0, bus.valid_out}, 32'h0);
        chk("br_instr", bus.instr_out,          32'h0);
        step();
        chk("br_next_instr", bus.instr_out, 32'h8C00_0040);
        chk("br_next_pcout", bus.pc_out,    32'h44);

        // All three redirects together: aligned JumpRegister target wins.
        bus.Jump = 1'b1; bus.JumpTarget = 32'h100;
        bus.JumpRegister = 1'b1; bus.JumpRegTarget = 32'h203;
        bus.Branch = 1'b1; bus.BranchTarget = 32'h80;
        step();
        clear_redirect();
        chk("prio_pc", bus.imem_addr, 32'h200);

        // Move to PC=0x20 with a valid word (from 0x1C) in IF/ID, then stall.
        bus.Jump = 1'b1; bus.JumpTarget = 32'h1C;
        step();
        clear_redirect();
        step();
        chk("pre_stall_pc", bus.imem_addr, 32'h20);
        bus.Stall = 1'b1; bus.Branch = 1'b1; bus.BranchTarget = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    bus.imem_addr,   32'h20);
            chk("stall_instr", bus.instr_out,   32'h8C00_001C);
            chk("stall_pcout", bus.pc_out,      32'h20);
            chk("stall_count", bus.fetch_count, 32'd6);
        end
        bus.Stall = 1'b0; clear_redirect();
        step();
        chk("resume_pc",    bus.imem_addr,   32'h24);
        chk("resume_instr", bus.instr_out,   32'h8C00_0020);
        chk("resume_count", bus.fetch_count, 32'd7);

        // Stall with Flush: PC held, IF/ID cleared.
        bus.Stall = 1'b1; bus.Flush = 1'b1;
        step();
        chk("sf_pc",    bus.imem_addr,          32'h24);
        chk("sf_instr", bus.instr_out,          32'h0);
        chk("sf_valid", {31'd0, bus.valid_out}, 32'h0);
        // Flush alone: PC advances, IF/ID squashed, nothing counted.
        bus.Stall = 1'b0;
        step();
        bus.Flush = 1'b0;
        chk("fl_pc",    bus.imem_addr,   32'h28);
        chk("fl_count", bus.fetch_count, 32'd7);

        // PC wrap at the top of the address space.
        bus.Jump = 1'b1; bus.JumpTarget = 32'hFFFF_FFF8;
        step();
        clear_redirect();
        step();
        chk("wrap_pre_pc", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc",    bus.imem_addr,   32'h0);
        chk("wrap_pcout", bus.pc_out,      32'h0);
        chk("wrap_instr", bus.instr_out,   32'h73FF_FFFC);
        chk("wrap_count", bus.fetch_count, 32'd9);

        // Reset mid-stream overrides a simultaneous jump.
        bus.Jump = 1'b1; bus.JumpTarget = 32'h48;
        step();
        chk("pc_at_48", bus.imem_addr, 32'h48);
        bus.JumpTarget = 32'h300; Reset = 1'b1;
        step();
        chk("mrst_pc",    bus.imem_addr,          32'h0);
        chk("mrst_valid", {31'd0, bus.valid_out}, 32'h0);
        chk("mrst_count", bus.fetch_count,        32'h0);
        Reset = 1'b0; clear_redirect();
        step();
        chk("post_rst_pc",    bus.imem_addr,   32'h4);
        chk("post_rst_instr", bus.instr_out,   32'h2008_0005);
        chk("post_rst_count", bus.fetch_count, 32'h1);

        @(posedge Clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_phase.md
Name: instruction_fetch_phase

Overview:
Fetch stage directly upstream of the decode phase. Holds the program counter (PC), drives the instruction-memory address, and selects the next PC from sequential, branch, jump and jump-register sources. Owns the IF/ID pipeline register, which supplies the decode phase's instruction and PC+4 inputs. Supports stall (hazard hold) and squash (redirect/flush).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on Reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on squash (sll $0,$0,0)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hazard hold; freezes PC and IF/ID
Flush  in  1  external squash of IF/ID contents
Branch  in  1  taken-branch resolved in decode
BranchTarget  in  32  branch target address from decode
Jump  in  1  j/jal resolved in decode
JumpTarget  in  32  jump target address from decode
JumpRegister  in  1  jr/jalr resolved in decode
JumpRegTarget  in  32  rs register value from decode
imem_addr  out  32  instruction memory address (= current PC)
imem_data  in  32  instruction word, combinational read of imem_addr
instr_out  out  32  IF/ID instruction to decode
pc_out  out  32  IF/ID PC+4 to decode
valid_out  out  1  IF/ID contents are a real fetched instruction
fetch_count  out  32  count of instructions latched valid into IF/ID

Behaviour:
- Reset (synchronous, active-high) sets PC=RESET_PC, instr_out=NOP_INSTR, pc_out=0, valid_out=0, fetch_count=0. Reset overrides all other inputs. A mid-operation reset takes effect on the next rising edge, with no residual redirect.
- imem_addr = PC, combinationally.
- Sequential increment: pc_plus4 = PC + 32'd4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect: redirect = JumpRegister | Jump | Branch.
- Next-PC priority: JumpRegister > Jump > Branch > pc_plus4.
- Target alignment: bits [1:0] of the selected target are forced to 2'b00.
- Per-edge update when Reset=0, highest precedence first:
  1. Stall=1: PC holds. Redirect inputs are ignored, because decode re-presents them after the stall.
     - Flush=1: IF/ID is loaded with NOP_INSTR, pc_out=0, valid_out=0.
     - Flush=0: IF/ID holds.
  2. Stall=0 and redirect=1: PC <= selected target. IF/ID is squashed (NOP_INSTR, valid_out=0). There is no branch delay slot.
  3. Stall=0 and Flush=1 with no redirect: PC <= pc_plus4, and IF/ID is squashed.
  4. Otherwise: PC <= pc_plus4, instr_out <= imem_data, pc_out <= pc_plus4, valid_out <= 1.
- Latency: the word at address A appears on instr_out one edge after PC=A, with pc_out=A+4.
- fetch_count increments by 1 exactly on edges where case 4 applies. It wraps from 32'hFFFF_FFFF to 0.
- Multiple redirect inputs asserted together resolve by priority only; this is not an error.
- No internal state machine beyond the PC, IF/ID and counter registers. Pipeline states are RUN, HOLD (Stall) and SQUASH (redirect/Flush), decoded from the inputs each cycle.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR
  - RESET_PC default
  - PC_INCR (32'd4)
  - a next-PC select encoding (NPC_SEQ, NPC_BR, NPC_J, NPC_JR) reused by decode/hazard logic
- One natural sub-module: if_id_register. It contains the IF/ID flops with hold, squash and load controls, plus valid_out.
- PC register and next-PC mux stay in the top.

Test Plan:
- Reset then free-run; imem returns 32'h2008_0005 at 0 and 32'h2009_0003 at 4.
  Required response: cycle 1 instr_out=32'h2008_0005, pc_out=4, valid_out=1. Cycle 2 instr_out=32'h2009_0003, pc_out=8. fetch_count=2.
- At PC=0x10, Branch=1, BranchTarget=0x40.
  Required response: next PC=0x40 and IF/ID squashed (valid_out=0, instr_out=NOP_INSTR). The following cycle latches the word at 0x40 with pc_out=0x44.
- Jump=1 (0x100), JumpRegister=1 (0x203), Branch=1 (0x80) all asserted together.
  Required response: PC=0x200, with alignment applied and JumpRegister winning.
- Stall=1 for 3 cycles at PC=0x20 with Branch=1 asserted.
  Required response: PC stays 0x20, IF/ID and fetch_count unchanged, branch ignored. After Stall drops, normal flow resumes.
- Stall=1 and Flush=1 together.
  Required response: PC held and IF/ID cleared to NOP_INSTR with valid_out=0. Then separately drive PC=32'hFFFF_FFFC free-running and confirm PC wraps to 0.
- Assert Reset mid-stream at PC=0x48 with Jump=1.
  Required response: next edge gives PC=RESET_PC, valid_out=0, fetch_count=0, and the jump is not taken.
